mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Parametrised single-port SRAM arbiter that lets the instruction-fetch stage and the data-memory stage share one external SRAM. Both requests arrive in the same cycle on a load/store. The block serialises them through a strobe-sequencing FSM with configurable wait states. It drives a pipeline-wide `Stall` while any request is outstanding, which generalises the old split Ram1/Ram2 arrangement to one memory of any width or speed.

## Interface
- `ADDR_W`, 18: SRAM address width.
- `DATA_W`, 16: SRAM data width.
- `WAIT_CYC`, 1: extra strobe cycles per access (0..15).
- `ARB_MODE`, 0: 0 = fixed data-port priority; 1 = round-robin.

Ports. One clock; reset is synchronous and active-high.
- `Clk` in 1: clock. All state changes on the rising edge.
- `Rst` in 1: synchronous, active-high reset.
- `IfReq` in 1: fetch read request. Held until `IfReady`.
- `IfAddr` in ADDR_W: fetch address.
- `IfData` out DATA_W: fetched word. Registered; held until the next fetch completes.
- `IfReady` out 1: one-cycle completion pulse.
- `DmRead` in 1: data read request. Held until `DmReady`.
- `DmWrite` in 1: data write request. Held until `DmReady`. Takes precedence if `DmRead` is also high.
- `DmAddr` in ADDR_W: data address.
- `DmWdata` in DATA_W: write data.
- `DmRdata` out DATA_W: read data. Registered; held until the next data read completes.
- `DmReady` out 1: one-cycle completion pulse.
- `Stall` out 1: combinational. Equals `(IfReq & ~IfReady) | ((DmRead|DmWrite) & ~DmReady)`.
- `Ram_EN` out 1: active-low chip enable.
- `Ram_OE` out 1: active-low read enable.
- `Ram_WE` out 1: active-low write enable.
- `Ram_address` out ADDR_W: SRAM address.
- `Ram_data` inout DATA_W: SRAM data. Driven only in write states, Z otherwise.

## Operation
- FSM states: IDLE, RD, WR_SETUP, WR_PULSE, DONE.
- IDLE:
  - Samples requests. If none, stays in IDLE.
  - Grant rule, `ARB_MODE=0`: data port wins.
  - Grant rule, `ARB_MODE=1`: when both ports request, the port not granted last wins. A 1-bit `last_grant` register resets to fetch, so the first contested grant goes to data.
  - On grant: latch the address, the write data and the grant owner.
  - Go to RD (read) or WR_SETUP (write).
- RD:
  - `EN=0`, `OE=0`.
  - Lasts WAIT_CYC+1 cycles, counted by the wait counter.
  - On the last cycle, capture `Ram_data` into the owner's read register. Then go to DONE.
- WR_SETUP:
  - 1 cycle with `EN=0`, `WE=1`, data driven.
  - Then go to WR_PULSE.
- WR_PULSE:
  - `WE=0` for WAIT_CYC+1 cycles, data driven.
  - Then go to DONE.
- DONE:
  - Pulse the owner's Ready.
  - `EN=1`, `OE=1`, `WE=1`.
  - Data stays driven for hold after a write.
  - Return to IDLE. IDLE always lasts at least one cycle, which gives bus turnaround.
- Requests whose inputs change while not granted are ignored. The latched address and data govern the in-flight access.
- A request dropped mid-access is illegal. The access still completes and Ready still pulses.
- Reset values, from any state: FSM=IDLE, `EN=OE=WE=1`, `Ram_address=0`, `Ram_data` Z, both Ready=0, `IfData=0`, `DmRdata=0`, wait counter=0, `last_grant`=fetch.
- Reset asserted mid-access aborts it with no Ready pulse. Strobes are inactive from the next edge.

## Timing
- Request seen in IDLE at edge t.
- Read latency: Ready high in cycle t+WAIT_CYC+2. Data is valid in that cycle.
- Write latency: Ready high in cycle t+WAIT_CYC+3.
- Throughput with both ports requesting: reads take WAIT_CYC+3 cycles each, including the IDLE cycle.
- `Ram_address` is stable from the first strobe cycle through DONE.
- Write data is stable from WR_SETUP through DONE.
- `Stall` falls in the Ready cycle of the last outstanding request, letting the pipeline advance on that edge.

## Structure
- Package `mem_arb_pkg`: state enum, `ARB_DATA`/`ARB_RR` mode constants, `GRANT_IF`/`GRANT_DM` encoding.
- Sub-module `wait_counter`:
  - 4-bit down-counter.
  - Loaded with WAIT_CYC on entry to RD or WR_PULSE.
  - Flags `last` when it reaches 0.
  - Cleared by `Rst`.

## Test plan
- Reset with strobes active in WR_PULSE (`WAIT_CYC=1`) -> next edge: `EN=OE=WE=1`, data Z, no Ready pulse, `Stall` follows the inputs only.
- Fetch only, `IfAddr=0x00010`, SRAM word 0x1234, `WAIT_CYC=1` -> `IfReady` in cycle t+3, `IfData=0x1234`, `OE` low for exactly 2 cycles.
- Write `DmAddr=0x00020`, `DmWdata=0xBEEF`, then read the same address -> `WE` low 2 cycles, `DmReady` at t+4; the read returns 0xBEEF.
- `ARB_MODE=0`, `IfReq` and `DmRead` raised together -> data served first (Ready at t+3), fetch Ready 4 cycles later; `Stall` high throughout until the fetch Ready cycle.
- `ARB_MODE=1`, both ports held continuously for 4 accesses -> grants alternate DM, IF, DM, IF.
- `WAIT_CYC=0` read -> Ready at t+2, `OE` low for 1 cycle.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and arbitration helper for mem_arbiter
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_DONE     = 3'd4
    } state_e;

    localparam int ARB_DATA = 0;
    localparam int ARB_RR   = 1;

    typedef enum logic {
        GRANT_IF = 1'b0,
        GRANT_DM = 1'b1
    } grant_e;

    // Data port wins unless only fetch requests, or round-robin mode
    // handed the previous grant to data.
    function automatic grant_e pick_grant(input logic   if_req,
                                          input logic   dm_req,
                                          input int     mode,
                                          input grant_e last);
        if (dm_req && (!if_req || mode != ARB_RR || last == GRANT_IF)) begin
            return GRANT_DM;
        end
        return GRANT_IF;
    endfunction

endpackage

// File: rtl/mem_arbiter_wait_counter.sv
// rtl/mem_arbiter_wait_counter.sv - wait-state down-counter for the strobe sequencer
//
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset, clears the count
//   load_i  load WAIT_CYC (asserted on the edge entering RD or WR_PULSE)
//   last_o  high while the count is zero: current strobe cycle is the final one
module wait_counter #(
    parameter int WAIT_CYC = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    output logic last_o
);

    localparam logic [3:0] LOAD_VAL = 4'(WAIT_CYC);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last_o = (cnt_q == 4'd0);

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port SRAM arbiter between fetch and data-memory stages
//
// Ports:
//   Clk, Rst                 clock, synchronous active-high reset
//   IfReq/IfAddr             fetch read request, held until IfReady
//   IfData/IfReady           registered fetched word, one-cycle completion pulse
//   DmRead/DmWrite/DmAddr    data request (write wins over read), held until DmReady
//   DmWdata                  write data
//   DmRdata/DmReady          registered read word, one-cycle completion pulse
//   Stall                    combinational: some request is still outstanding
//   Ram_EN/Ram_OE/Ram_WE     active-low SRAM strobes (registered)
//   Ram_address              SRAM address (latched at grant)
//   Ram_data                 SRAM data bus, driven only during writes
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 16,
    parameter int WAIT_CYC = 1,
    parameter int ARB_MODE = 0
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IfReq,
    input  logic [ADDR_W-1:0] IfAddr,
    output logic [DATA_W-1:0] IfData,
    output logic              IfReady,
    input  logic              DmRead,
    input  logic              DmWrite,
    input  logic [ADDR_W-1:0] DmAddr,
    input  logic [DATA_W-1:0] DmWdata,
    output logic [DATA_W-1:0] DmRdata,
    output logic              DmReady,
    output logic              Stall,
    output logic              Ram_EN,
    output logic              Ram_OE,
    output logic              Ram_WE,
    output logic [ADDR_W-1:0] Ram_address,
    inout  wire  [DATA_W-1:0] Ram_data
);

    state_e              state_q;
    grant_e              owner_q;
    grant_e              last_grant_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                drive_q;
    logic                en_q;
    logic                oe_q;
    logic                we_q;
    logic                if_ready_q;
    logic                dm_ready_q;
    logic [DATA_W-1:0]   if_data_q;
    logic [DATA_W-1:0]   dm_rdata_q;

    logic                dm_req;
    logic                any_req;
    grant_e              grant;
    logic                grant_write;
    logic                wc_load;
    logic                wc_last;

    assign dm_req      = DmRead | DmWrite;
    assign any_req     = IfReq | dm_req;
    assign grant       = pick_grant(IfReq, dm_req, ARB_MODE, last_grant_q);
    assign grant_write = (grant == GRANT_DM) && DmWrite;

    // Count starts on the edge that enters the strobe phase so the first
    // RD/WR_PULSE cycle already sees WAIT_CYC.
    assign wc_load = ((state_q == ST_IDLE) && any_req && !grant_write) ||
                     (state_q == ST_WR_SETUP);

    wait_counter #(
        .WAIT_CYC (WAIT_CYC)
    ) u_wait_counter (
        .clk_i  (Clk),
        .rst_i  (Rst),
        .load_i (wc_load),
        .last_o (wc_last)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= GRANT_IF;
            last_grant_q <= GRANT_IF;
            addr_q       <= '0;
            wdata_q      <= '0;
            drive_q      <= 1'b0;
            en_q         <= 1'b1;
            oe_q         <= 1'b1;
            we_q         <= 1'b1;
            if_ready_q   <= 1'b0;
            dm_ready_q   <= 1'b0;
            if_data_q    <= '0;
            dm_rdata_q   <= '0;
        end else begin
            if_ready_q <= 1'b0;
            dm_ready_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (any_req) begin
                        owner_q      <= grant;
                        last_grant_q <= grant;
                        addr_q       <= (grant == GRANT_DM) ? DmAddr : IfAddr;
                        wdata_q      <= DmWdata;
                        en_q         <= 1'b0;
                        if (grant_write) begin
                            drive_q <= 1'b1;
                            we_q    <= 1'b1;
                            state_q <= ST_WR_SETUP;
                        end else begin
                            oe_q    <= 1'b0;
                            state_q <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    if (wc_last) begin
                        if (owner_q == GRANT_DM) begin
                            dm_rdata_q <= Ram_data;
                            dm_ready_q <= 1'b1;
                        end else begin
                            if_data_q  <= Ram_data;
                            if_ready_q <= 1'b1;
                        end
                        en_q    <= 1'b1;
                        oe_q    <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_WR_SETUP: begin
                    we_q    <= 1'b0;
                    state_q <= ST_WR_PULSE;
                end
                ST_WR_PULSE: begin
                    if (wc_last) begin
                        we_q       <= 1'b1;
                        en_q       <= 1'b1;
                        dm_ready_q <= 1'b1;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Bus released here; IDLE then gives a turnaround cycle.
                    drive_q <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign IfData      = if_data_q;
    assign IfReady     = if_ready_q;
    assign DmRdata     = dm_rdata_q;
    assign DmReady     = dm_ready_q;
    assign Ram_EN      = en_q;
    assign Ram_OE      = oe_q;
    assign Ram_WE      = we_q;
    assign Ram_address = addr_q;
    assign Ram_data    = drive_q ? wdata_q : {DATA_W{1'bz}};

    assign Stall = (IfReq & ~if_ready_q) | (dm_req & ~dm_ready_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed table-driven bench for mem_arbiter
module tb_mem_arbiter;

    typedef struct {
        int          inst;
        logic        ifq;
        logic [17:0] ia;
        logic        rd;
        logic        wr;
        logic [17:0] da;
        logic [15:0] wd;
        int          if_lat;
        int          dm_lat;
        int          oe;
        int          we;
        logic [15:0] ifd;
        logic [15:0] dmd;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req   [2];
    logic [17:0] if_addr  [2];
    logic [15:0] if_data  [2];
    logic        if_ready [2];
    logic        dm_read  [2];
    logic        dm_write [2];
    logic [17:0] dm_addr  [2];
    logic [15:0] dm_wdata [2];
    logic [15:0] dm_rdata [2];
    logic        dm_ready [2];
    logic        stall    [2];
    logic        ram_en   [2];
    logic        ram_oe   [2];
    logic        ram_we   [2];
    logic [17:0] ram_addr [2];
    wire  [15:0] ram_data_a;
    wire  [15:0] ram_data_b;
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(1), .ARB_MODE(0)) dut_a (
        .Clk(clk), .Rst(rst),
        .IfReq(if_req[0]), .IfAddr(if_addr[0]), .IfData(if_data[0]), .IfReady(if_ready[0]),
        .DmRead(dm_read[0]), .DmWrite(dm_write[0]), .DmAddr(dm_addr[0]), .DmWdata(dm_wdata[0]),
        .DmRdata(dm_rdata[0]), .DmReady(dm_ready[0]), .Stall(stall[0]),
        .Ram_EN(ram_en[0]), .Ram_OE(ram_oe[0]), .Ram_WE(ram_we[0]),
        .Ram_address(ram_addr[0]), .Ram_data(ram_data_a)
    );

    mem_arbiter #(.ADDR_W(18), .DATA_W(16), .WAIT_CYC(0), .ARB_MODE(1)) dut_b (
        .Clk(clk), .Rst(rst),
        .IfReq(if_req[1]), .IfAddr(if_addr[1]), .IfData(if_data[1]), .IfReady(if_ready[1]),
        .DmRead(dm_read[1]), .DmWrite(dm_write[1]), .DmAddr(dm_addr[1]), .DmWdata(dm_wdata[1]),
        .DmRdata(dm_rdata[1]), .DmReady(dm_ready[1]), .Stall(stall[1]),
        .Ram_EN(ram_en[1]), .Ram_OE(ram_oe[1]), .Ram_WE(ram_we[1]),
        .Ram_address(ram_addr[1]), .Ram_data(ram_data_b)
    );

    // Asynchronous-read SRAM models, written while EN and WE are both low.
    assign ram_data_a = (!ram_en[0] && !ram_oe[0]) ? mem_a[ram_addr[0][7:0]] : 16'hzzzz;
    assign ram_data_b = (!ram_en[1] && !ram_oe[1]) ? mem_b[ram_addr[1][7:0]] : 16'hzzzz;

    always @(posedge clk) begin
        if (rst) begin
            mem_a[8'h10] <= 16'h1234;
            mem_a[8'h11] <= 16'h4321;
        end else if (!ram_en[0] && !ram_we[0]) begin
            mem_a[ram_addr[0][7:0]] <= ram_data_a;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            mem_b[8'h10] <= 16'h1234;
            mem_b[8'h11] <= 16'h4321;
        end else if (!ram_en[1] && !ram_we[1]) begin
            mem_b[ram_addr[1][7:0]] <= ram_data_b;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int inst, input logic ifq, input logic [17:0] ia,
                                input logic rd, input logic wr, input logic [17:0] da,
                                input logic [15:0] wd, input int il, input int dl,
                                input int oe, input int we, input logic [15:0] ifd,
                                input logic [15:0] dmd);
        vec_t v;
        v.inst = inst; v.ifq = ifq; v.ia = ia; v.rd = rd; v.wr = wr; v.da = da; v.wd = wd;
        v.if_lat = il; v.dm_lat = dl; v.oe = oe; v.we = we; v.ifd = ifd; v.dmd = dmd;
        return v;
    endfunction

    // Raise the requests, then sample each cycle at the falling edge.
    // Cycle n is the n-th cycle after the edge at which IDLE sees the request.
    task automatic run(input vec_t v, output int if_lat, output int dm_lat,
                       output int oe_n, output int we_n, output int stall_err);
        int  k;
        int  total;
        bit  pend_if;
        bit  pend_dm;
        bit  drop_if;
        bit  drop_dm;
        k = v.inst;
        total = (v.if_lat > v.dm_lat) ? v.if_lat : v.dm_lat;
        if_lat = 0; dm_lat = 0; oe_n = 0; we_n = 0; stall_err = 0;
        if_req[k] = v.ifq; if_addr[k] = v.ia;
        dm_read[k] = v.rd; dm_write[k] = v.wr; dm_addr[k] = v.da; dm_wdata[k] = v.wd;
        pend_if = v.ifq;
        pend_dm = v.rd | v.wr;
        @(posedge clk);
        for (int n = 1; n <= 20 && (pend_if || pend_dm); n++) begin
            @(negedge clk);
            if (!ram_oe[k]) oe_n++;
            if (!ram_we[k]) we_n++;
            if (stall[k] !== (n < total)) stall_err++;
            drop_if = 1'b0;
            drop_dm = 1'b0;
            if (pend_if && if_ready[k]) begin if_lat = n; pend_if = 1'b0; drop_if = 1'b1; end
            if (pend_dm && dm_ready[k]) begin dm_lat = n; pend_dm = 1'b0; drop_dm = 1'b1; end
            @(posedge clk);
            #1;
            if (drop_if) if_req[k] = 1'b0;
            if (drop_dm) begin dm_read[k] = 1'b0; dm_write[k] = 1'b0; end
        end
        if_req[k] = 1'b0; dm_read[k] = 1'b0; dm_write[k] = 1'b0;
    endtask

    task automatic apply_vec(input string tag, input vec_t v);
        int il, dl, oe_n, we_n, se;
        run(v, il, dl, oe_n, we_n, se);
        if (v.ifq) chk({tag, "_if_lat"}, il, v.if_lat);
        if (v.rd | v.wr) chk({tag, "_dm_lat"}, dl, v.dm_lat);
        chk({tag, "_oe_cycles"}, oe_n, v.oe);
        chk({tag, "_we_cycles"}, we_n, v.we);
        chk({tag, "_stall"}, se, 0);
        chk({tag, "_ifdata"}, {16'h0, if_data[v.inst]}, {16'h0, v.ifd});
        chk({tag, "_dmrdata"}, {16'h0, dm_rdata[v.inst]}, {16'h0, v.dmd});
    endtask

    vec_t vecs [13];
    int   hs_g   [4];
    int   hs_t   [4];
    int   exp_g  [4];
    int   exp_t  [4];
    int   hs_cnt;
    bit   seen;
    int   rdy_cnt;

    initial begin
        vecs[0]  = mk(0, 1, 18'h10, 0, 0, 18'h00, 16'h0000, 3, 0, 2, 0, 16'h1234, 16'h0000);
        vecs[1]  = mk(0, 0, 18'h00, 0, 1, 18'h20, 16'hBEEF, 0, 4, 0, 2, 16'h1234, 16'h0000);
        vecs[2]  = mk(0, 0, 18'h00, 1, 0, 18'h20, 16'h0000, 0, 3, 2, 0, 16'h1234, 16'hBEEF);
        vecs[3]  = mk(0, 0, 18'h00, 0, 1, 18'h21, 16'h5A5A, 0, 4, 0, 2, 16'h1234, 16'hBEEF);
        vecs[4]  = mk(0, 1, 18'h21, 0, 0, 18'h00, 16'h0000, 3, 0, 2, 0, 16'h5A5A, 16'hBEEF);
        vecs[5]  = mk(0, 0, 18'h00, 1, 1, 18'h22, 16'h0F0F, 0, 4, 0, 2, 16'h5A5A, 16'hBEEF);
        vecs[6]  = mk(0, 0, 18'h00, 1, 0, 18'h22, 16'h0000, 0, 3, 2, 0, 16'h5A5A, 16'h0F0F);
        vecs[7]  = mk(0, 1, 18'h10, 1, 0, 18'h20, 16'h0000, 7, 3, 4, 0, 16'h1234, 16'hBEEF);
        vecs[8]  = mk(0, 1, 18'h21, 0, 1, 18'h23, 16'hA5A5, 8, 4, 2, 2, 16'h5A5A, 16'hBEEF);
        vecs[9]  = mk(1, 0, 18'h00, 0, 1, 18'h30, 16'h7777, 0, 3, 0, 1, 16'h4321, 16'h1234);
        vecs[10] = mk(1, 0, 18'h00, 1, 0, 18'h30, 16'h0000, 0, 2, 1, 0, 16'h4321, 16'h7777);
        vecs[11] = mk(1, 1, 18'h11, 0, 0, 18'h00, 16'h0000, 2, 0, 1, 0, 16'h4321, 16'h7777);
        vecs[12] = mk(1, 1, 18'h30, 1, 0, 18'h10, 16'h0000, 5, 2, 2, 0, 16'h7777, 16'h1234);
        exp_g = '{1, 0, 1, 0};
        exp_t = '{2, 5, 8, 11};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            if_req[k] = 1'b0; if_addr[k] = '0; dm_read[k] = 1'b0; dm_write[k] = 1'b0;
            dm_addr[k] = '0; dm_wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d_strobes", k), {ram_en[k], ram_oe[k], ram_we[k]}, 3'b111);
            chk($sformatf("rst%0d_addr", k), ram_addr[k], 0);
            chk($sformatf("rst%0d_ifdata", k), if_data[k], 0);
            chk($sformatf("rst%0d_dmrdata", k), dm_rdata[k], 0);
            chk($sformatf("rst%0d_ready", k), {if_ready[k], dm_ready[k]}, 2'b00);
            chk($sformatf("rst%0d_stall", k), stall[k], 0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Round-robin with both ports held: grants must alternate DM, IF, DM, IF.
        hs_cnt = 0;
        for (int j = 0; j < 4; j++) begin hs_g[j] = -1; hs_t[j] = -1; end
        if_req[1] = 1'b1; if_addr[1] = 18'h11; dm_read[1] = 1'b1; dm_addr[1] = 18'h10;
        @(posedge clk);
        for (int n = 1; n <= 16 && hs_cnt < 4; n++) begin
            @(negedge clk);
            if (dm_ready[1] && hs_cnt < 4) begin hs_g[hs_cnt] = 1; hs_t[hs_cnt] = n; hs_cnt++; end
            if (if_ready[1] && hs_cnt < 4) begin hs_g[hs_cnt] = 0; hs_t[hs_cnt] = n; hs_cnt++; end
            @(posedge clk);
            #1;
        end
        if_req[1] = 1'b0; dm_read[1] = 1'b0;
        for (int j = 0; j < 4; j++) begin
            chk($sformatf("rr_grant%0d", j), hs_g[j], exp_g[j]);
            chk($sformatf("rr_cycle%0d", j), hs_t[j], exp_t[j]);
        end
        chk("rr_ifdata", if_data[1], 16'h4321);
        chk("rr_dmrdata", dm_rdata[1], 16'h1234);

        for (int i = 0; i < 13; i++) begin
            apply_vec($sformatf("v%0d", i), vecs[i]);
        end

        // Reset while the write strobe is active.
        dm_write[0] = 1'b1; dm_addr[0] = 18'h24; dm_wdata[0] = 16'h1111;
        @(posedge clk);
        seen = 1'b0;
        for (int n = 1; n <= 10 && !seen; n++) begin
            @(negedge clk);
            if (!ram_we[0]) seen = 1'b1;
        end
        chk("rstw_we_seen", seen, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rstw_strobes", {ram_en[0], ram_oe[0], ram_we[0]}, 3'b111);
        chk("rstw_ready", dm_ready[0], 0);
        chk("rstw_stall_held", stall[0], 1);
        @(posedge clk);
        #1;
        dm_write[0] = 1'b0;
        @(negedge clk);
        chk("rstw_stall_dropped", stall[0], 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_cnt = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (dm_ready[0] || if_ready[0]) rdy_cnt++;
        end
        chk("rstw_no_ready", rdy_cnt, 0);
        @(posedge clk);
        #1;
        apply_vec("post_rst", mk(0, 0, 18'h00, 1, 0, 18'h20, 16'h0000, 0, 3, 2, 0, 16'h0000, 16'hBEEF));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
